// File: rtl/game_pkg.sv
// game_pkg: shared state encoding, winner codes and timing defaults for the game timer
package game_pkg;

    typedef enum logic [2:0] {IDLE, ARMED, RUN_A, RUN_B, PAUSE, DONE} state_e;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_A    = 2'b01;
    localparam logic [1:0] WIN_B    = 2'b10;

    localparam int unsigned LOAD_SHORT_DEF = 100;
    localparam int unsigned LOAD_LONG_DEF  = 300;
    localparam int unsigned WARN_TH_DEF    = 50;

    function automatic logic [1:0] win_of(input logic loser_is_a);
        return loser_is_a ? WIN_B : WIN_A;
    endfunction

endpackage

// File: rtl/move_counter.sv
// move_counter: per-player countdown with load, decrement enable, hold at zero and warning flag
module move_counter import game_pkg::*; #(
    parameter int unsigned CNT_W   = 10,
    parameter int unsigned WARN_TH = WARN_TH_DEF
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt,
    output logic             zero_next,
    output logic             warn
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // load wins over decrement; decrement stops at zero so the count never wraps
    always_comb cnt_d = load ? load_val : (dec && cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;

    // count register
    always_ff @(posedge clk or negedge clr_n)
        if (!clr_n) cnt_q <= '0;
        else cnt_q <= cnt_d;

    assign cnt       = cnt_q;
    assign zero_next = cnt_q == CNT_W'(1);
    assign warn      = cnt_q != '0 && cnt_q <= CNT_W'(WARN_TH);

endmodule

// File: rtl/game_turn_ctrl.sv
// game_turn_ctrl: chess-clock turn FSM; define GAME_PAUSE_EN to build the pause feature
module game_turn_ctrl import game_pkg::*; #(
    parameter int unsigned CNT_W      = 10,
    parameter int unsigned LOAD_SHORT = LOAD_SHORT_DEF,
    parameter int unsigned LOAD_LONG  = LOAD_LONG_DEF,
    parameter int unsigned WARN_TH    = WARN_TH_DEF
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             tick,
    input  logic             mode,
    input  logic             start,
    input  logic             btn_a,
    input  logic             btn_b,
    input  logic             concede_a,
    input  logic             concede_b,
    input  logic             pause_req,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b,
    output logic             run_a,
    output logic             run_b,
    output logic             paused,
    output logic             warn_a,
    output logic             warn_b,
    output logic [1:0]       winner,
    output logic             game_over
);

    if ((LOAD_LONG >> CNT_W) != 0 || (LOAD_SHORT >> CNT_W) != 0) begin : g_load_fit
        $error("game_turn_ctrl: move load does not fit in CNT_W bits");
    end

    state_e           state_q, state_d;
    logic             mode_q, mode_d;
    logic [1:0]       winner_q, winner_d;
    logic             load_a, load_b, dec_a, dec_b;
    logic             zero_a, zero_b, warn_a_c, warn_b_c;
    logic             live;
    logic [CNT_W-1:0] load_val;

`ifdef GAME_PAUSE_EN
    logic             who_q, who_d;
`else
    logic             unused_pause;
    assign unused_pause = pause_req;
`endif

    assign live     = state_q inside {ARMED, RUN_A, RUN_B, PAUSE};
    assign load_val = (start ? mode : mode_q) ? CNT_W'(LOAD_LONG) : CNT_W'(LOAD_SHORT);

    // next state with priority start > concede > timeout > btn > pause_req > tick
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        winner_d = winner_q;
        load_a   = 1'b0;
        load_b   = 1'b0;
        dec_a    = 1'b0;
        dec_b    = 1'b0;
`ifdef GAME_PAUSE_EN
        who_d    = who_q;
`endif
        if (start) begin
            mode_d   = mode;
            load_a   = 1'b1;
            load_b   = 1'b1;
            winner_d = WIN_NONE;
            state_d  = ARMED;
        end else if (live && (concede_a ^ concede_b)) begin
            winner_d = win_of(concede_a);
            state_d  = DONE;
        end else if (state_q == RUN_A) begin
            if (tick && zero_a) begin
                dec_a    = 1'b1;
                winner_d = WIN_B;
                state_d  = DONE;
            end else if (btn_a) begin
                load_b  = 1'b1;
                state_d = RUN_B;
            end
`ifdef GAME_PAUSE_EN
            else if (pause_req) begin
                who_d   = 1'b0;
                state_d = PAUSE;
            end
`endif
            else dec_a = tick;
        end else if (state_q == RUN_B) begin
            if (tick && zero_b) begin
                dec_b    = 1'b1;
                winner_d = WIN_A;
                state_d  = DONE;
            end else if (btn_b) begin
                load_a  = 1'b1;
                state_d = RUN_A;
            end
`ifdef GAME_PAUSE_EN
            else if (pause_req) begin
                who_d   = 1'b1;
                state_d = PAUSE;
            end
`endif
            else dec_b = tick;
        end else if (state_q == ARMED) begin
            if (btn_a && !btn_b) state_d = RUN_B;
            else if (btn_b && !btn_a) state_d = RUN_A;
        end
`ifdef GAME_PAUSE_EN
        else if (state_q == PAUSE && pause_req) state_d = who_q ? RUN_B : RUN_A;
`endif
    end

    // state, latched game mode and result registers
    always_ff @(posedge clk or negedge clr_n)
        if (!clr_n) begin
            state_q  <= IDLE;
            mode_q   <= 1'b0;
            winner_q <= WIN_NONE;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            winner_q <= winner_d;
        end

`ifdef GAME_PAUSE_EN
    // which player resumes when the pause ends
    always_ff @(posedge clk or negedge clr_n)
        if (!clr_n) who_q <= 1'b0;
        else who_q <= who_d;
    assign paused = state_q == PAUSE;
`else
    assign paused = 1'b0;
`endif

    move_counter #(.CNT_W(CNT_W), .WARN_TH(WARN_TH)) u_cnt_a (
        .clk(clk), .clr_n(clr_n), .load(load_a), .dec(dec_a), .load_val(load_val),
        .cnt(cnt_a), .zero_next(zero_a), .warn(warn_a_c)
    );

    move_counter #(.CNT_W(CNT_W), .WARN_TH(WARN_TH)) u_cnt_b (
        .clk(clk), .clr_n(clr_n), .load(load_b), .dec(dec_b), .load_val(load_val),
        .cnt(cnt_b), .zero_next(zero_b), .warn(warn_b_c)
    );

    assign run_a     = state_q == RUN_A;
    assign run_b     = state_q == RUN_B;
    assign warn_a    = run_a && warn_a_c;
    assign warn_b    = run_b && warn_b_c;
    assign winner    = winner_q;
    assign game_over = state_q == DONE;

endmodule

// File: tb/tb_game_turn_ctrl.sv
// tb_game_turn_ctrl: directed and random stimulus against a behavioural chess-clock model
module tb_game_turn_ctrl;

    logic clk = 0, clr_n = 0, tick = 0, mode = 0, start = 0;
    logic btn_a = 0, btn_b = 0, concede_a = 0, concede_b = 0, pause_req = 0;
    logic [9:0] cnt_a, cnt_b;
    logic run_a, run_b, paused, warn_a, warn_b, game_over;
    logic [1:0] winner;
    int total = 0, bad = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    game_turn_ctrl dut (
        .clk(clk), .clr_n(clr_n), .tick(tick), .mode(mode), .start(start),
        .btn_a(btn_a), .btn_b(btn_b), .concede_a(concede_a), .concede_b(concede_b),
        .pause_req(pause_req), .cnt_a(cnt_a), .cnt_b(cnt_b), .run_a(run_a), .run_b(run_b),
        .paused(paused), .warn_a(warn_a), .warn_b(warn_b), .winner(winner), .game_over(game_over)
    );

`ifdef GAME_PAUSE_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif
    localparam int P_IDLE = 0, P_ARM = 1, P_RUN = 2, P_PAUSE = 3, P_DONE = 4;

    int ph = P_IDLE, runner = 0, mmode = 0, win = 0;
    int mc[2] = '{0, 0};
    bit mb[2];

    function automatic int ld(input int m);
        return m ? 300 : 100;
    endfunction

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            ph = P_IDLE; mc[0] = 0; mc[1] = 0; win = 0; mmode = 0;
        end else begin
            mb[0] = btn_a; mb[1] = btn_b;
            if (start) begin
                mmode = mode; mc[0] = ld(mmode); mc[1] = ld(mmode); win = 0; ph = P_ARM;
            end else if ((concede_a != concede_b) && ph >= P_ARM && ph <= P_PAUSE) begin
                ph = P_DONE; win = concede_a ? 2 : 1;
            end else if (ph == P_RUN) begin
                if (tick && mc[runner] == 1) begin
                    mc[runner] = 0; ph = P_DONE; win = (runner == 0) ? 2 : 1;
                end else if (mb[runner]) begin
                    mc[1 - runner] = ld(mmode); runner = 1 - runner;
                end else if (PEN && pause_req) ph = P_PAUSE;
                else if (tick && mc[runner] > 0) mc[runner] = mc[runner] - 1;
            end else if (ph == P_ARM) begin
                if (btn_a && !btn_b) begin ph = P_RUN; runner = 1; end
                else if (btn_b && !btn_a) begin ph = P_RUN; runner = 0; end
            end else if (ph == P_PAUSE && pause_req) ph = P_RUN;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (chk_en) begin
        automatic bit ra = ph == P_RUN && runner == 0;
        automatic bit rb = ph == P_RUN && runner == 1;
        chk("cnt_a", cnt_a, mc[0]);
        chk("cnt_b", cnt_b, mc[1]);
        chk("run_a", run_a, ra);
        chk("run_b", run_b, rb);
        chk("paused", paused, ph == P_PAUSE);
        chk("warn_a", warn_a, ra && mc[0] > 0 && mc[0] <= 50);
        chk("warn_b", warn_b, rb && mc[1] > 0 && mc[1] <= 50);
        chk("winner", winner, win);
        chk("game_over", game_over, ph == P_DONE);
    end

    task automatic step(input bit t, s, ba, bb, ca, cb, pr);
        tick = t; start = s; btn_a = ba; btn_b = bb; concede_a = ca; concede_b = cb; pause_req = pr;
        @(negedge clk);
        tick = 0; start = 0; btn_a = 0; btn_b = 0; concede_a = 0; concede_b = 0; pause_req = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        clr_n = 1; chk_en = 1;
        chk("rst cnt_a", cnt_a, 0);
        chk("rst run_a", run_a, 0);
        chk("rst winner", winner, 0);
        chk("rst game_over", game_over, 0);
        // new short game, B hands over so A runs
        mode = 0; step(0, 1, 0, 0, 0, 0, 0);
        chk("start cnt_a", cnt_a, 100);
        chk("start cnt_b", cnt_b, 100);
        step(0, 0, 0, 1, 0, 0, 0);
        chk("armed btn_b run_a", run_a, 1);
        repeat (10) step(1, 0, 0, 0, 0, 0, 0);
        chk("10 ticks cnt_a", cnt_a, 90);
        step(1, 0, 1, 0, 0, 0, 0);
        chk("handover cnt_a", cnt_a, 90);
        chk("handover cnt_b", cnt_b, 100);
        chk("handover run_b", run_b, 1);
        // long game, B times out
        mode = 1; step(0, 1, 0, 0, 0, 0, 0); mode = 0;
        step(0, 0, 1, 0, 0, 0, 0);
        for (int i = 1; i <= 300; i++) begin
            step(1, 0, 0, 0, 0, 0, 0);
            if (i == 249) chk("warn_b at 51", warn_b, 0);
            if (i == 250) begin chk("cnt_b at 250", cnt_b, 50); chk("warn_b at 50", warn_b, 1); end
            if (i == 299) chk("no winner at 1", winner, 0);
        end
        chk("timeout game_over", game_over, 1);
        chk("timeout winner", winner, 1);
        chk("timeout cnt_b", cnt_b, 0);
        repeat (5) step(1, 0, 0, 0, 0, 0, 0);
        chk("hold cnt_b", cnt_b, 0);
        // concession handling
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1, 0);
        chk("double concede run_a", run_a, 1);
        step(0, 0, 1, 0, 1, 0, 0);
        chk("concede game_over", game_over, 1);
        chk("concede winner", winner, 2);
        // pause
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
`ifdef GAME_PAUSE_EN
        repeat (20) step(1, 0, 0, 0, 0, 0, 0);
        chk("paused cnt_a", cnt_a, 100);
        chk("paused flag", paused, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("resume run_a", run_a, 1);
`else
        chk("no pause flag", paused, 0);
        chk("no pause run_a", run_a, 1);
`endif
        step(1, 0, 0, 0, 0, 0, 0);
        chk("after pause cnt_a", cnt_a, 99);
        // asynchronous clear mid-game
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        repeat (63) step(1, 0, 0, 0, 0, 0, 0);
        chk("pre clear cnt_b", cnt_b, 37);
        #2 clr_n = 0;
        #1;
        chk("clr cnt_b", cnt_b, 0);
        chk("clr run_b", run_b, 0);
        chk("clr warn_b", warn_b, 0);
        @(negedge clk);
        clr_n = 1;
        step(0, 0, 0, 1, 0, 0, 0);
        chk("idle ignores btn", run_a, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        chk("restart cnt_a", cnt_a, 100);
        // random play
        for (int seg = 0; seg < 6; seg++) begin
            automatic int br = (seg % 2) ? 200 : 4;
            mode = 1'($urandom); step(0, 1, 0, 0, 0, 0, 0);
            repeat (500) begin
                mode = 1'($urandom);
                step($urandom_range(0, 1) == 1, $urandom_range(0, 299) == 0,
                     $urandom_range(0, br - 1) == 0, $urandom_range(0, br - 1) == 0,
                     $urandom_range(0, 149) == 0, $urandom_range(0, 149) == 0,
                     $urandom_range(0, 19) == 0);
            end
        end
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/game_turn_ctrl.md
# game_turn_ctrl

Chess-clock turn controller for the two-player game timer. It takes debounced player strobes and a tenth-second tick, and decides whose clock runs. It owns both per-move countdowns and detects timeout, concession and pause. Its outputs feed the BCD display converter, the warning-LED blinker and the buzzer driver, which replaces the scattered flag logic feeding a free-running counter.

## Interface
- CNT_W, 10: countdown width, in tenths of a second.
- LOAD_SHORT, 100: per-move load when mode=0 (10.0 s).
- LOAD_LONG, 300: per-move load when mode=1 (30.0 s).
- WARN_TH, 50: warning threshold; warn asserted when 0 < cnt ≤ WARN_TH.
- clk  in  1  system clock; the only clock.
- clr_n  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle strobe every 0.1 s, synchronous to clk.
- mode  in  1  0 = 10 s game, 1 = 30 s game; sampled only on start.
- start  in  1  one-cycle strobe: new game.
- btn_a, btn_b  in  1  one-cycle strobes: player ends own move.
- concede_a, concede_b  in  1  one-cycle strobes: player resigns.
- pause_req  in  1  one-cycle strobe: toggle pause.
- cnt_a, cnt_b  out  CNT_W  remaining time per player, in tenths.
- run_a, run_b  out  1  that player's clock is running.
- paused  out  1  game held.
- warn_a, warn_b  out  1  running player's clock at or below WARN_TH.
- winner  out  2  00 none, 01 A, 10 B.
- game_over  out  1  high while in DONE.

## Operation
- States: IDLE, ARMED, RUN_A, RUN_B, PAUSE, DONE. The reset state is IDLE.
- Reset values: cnt_a = cnt_b = 0; all 1-bit outputs 0; winner = 00.
- start, from any state: latch mode, load both counters with LOAD(mode), clear winner, go to ARMED. This is the only way out of IDLE and DONE.
- ARMED:
  - btn_a goes to RUN_B.
  - btn_b goes to RUN_A.
  - If both are high in the same cycle, both are ignored.
- RUN_A:
  - tick decrements cnt_a.
  - btn_a reloads cnt_b with LOAD and goes to RUN_B.
  - btn_b is ignored.
  - RUN_B mirrors RUN_A.
- Timeout: when a tick takes the running counter from 1 to 0, go to DONE with winner = opponent. The counter holds at 0 and never wraps.
- Concession: a single concede_x in ARMED, RUN or PAUSE goes to DONE with winner = opponent; the counters freeze. If concede_a and concede_b are high together, both are ignored.
- pause_req:
  - In RUN_x, go to PAUSE and remember x.
  - In PAUSE, return to the remembered RUN_x.
  - In other states it is ignored.
  - In PAUSE, tick and btn_a/btn_b are ignored.
- Same-cycle priority: start > concede > timeout > btn > pause_req > plain tick. The winning event is applied; all other strobes in that cycle are dropped.
- run_a = (state == RUN_A), run_b = (state == RUN_B).
- warn_x = run_x && cnt_x != 0 && cnt_x ≤ WARN_TH.
- Load arithmetic is unsigned CNT_W bits. LOAD_LONG must fit in CNT_W; elaboration fails if it does not.

## Timing
- All outputs are registered. Every strobe takes effect on the clk edge where it is sampled high, and is visible the following cycle.
- A tick coincident with btn_x of the running player is consumed by the handover. The outgoing counter is not decremented; the incoming counter is loaded, not decremented.
- Ticks begin decrementing the incoming counter from the first tick after the handover cycle.
- Timeout latency: DONE and winner are visible one cycle after the tick that produces 0.
- Asserting clr_n low mid-game returns all outputs to reset values immediately, with no clock required.
- mode changes outside a start cycle have no effect until the next start.

## Configuration
- GAME_PAUSE_EN defined: pause_req is honoured and the PAUSE state exists as described.
- GAME_PAUSE_EN undefined:
  - pause_req is ignored.
  - paused is tied to 0.
  - The PAUSE state and the remembered-player register are not built.
  - All other behaviour is identical.

## Structure
- Shared package game_pkg holds:
  - the state enum;
  - winner codes (WIN_NONE, WIN_A, WIN_B);
  - LOAD_SHORT and LOAD_LONG defaults;
  - WARN_TH.
- One sub-module, move_counter, instantiated twice. It provides load, a decrement-enable, hold-at-zero, and outputs zero_next and warn. The FSM stays in game_turn_ctrl.

## Test plan
- Reset, then start with mode=0 -> cnt_a = cnt_b = 100, ARMED, winner = 00. Then btn_b -> run_a = 1.
- RUN_A, 10 ticks, then btn_a -> cnt_a = 90, cnt_b reloaded to 100, run_b = 1. A tick in the same cycle as btn_a leaves cnt_a at 90.
- mode=1, RUN_B, 300 ticks:
  - warn_b rises when cnt_b = 50;
  - on the 300th tick, DONE next cycle with winner = 01 and cnt_b = 0;
  - further ticks leave cnt_b at 0.
- RUN_A with concede_a and btn_a in the same cycle -> DONE, winner = 10. concede_a and concede_b together -> no state change.
- With GAME_PAUSE_EN defined: pause_req in RUN_A, then 20 ticks -> cnt_a unchanged and paused = 1. A second pause_req resumes RUN_A. With it undefined -> pause_req has no effect.
- clr_n asserted during RUN_B with cnt_b = 37 -> all outputs 0 and state IDLE asynchronously. start is required to resume.
